// File: rtl/wb_motor_pad_mux.sv
// Wishbone-controlled arbiter of NUM_CH bidirectional motor pads between DSHOT and the
// half-duplex serial bridge, with an all-low guard interval and a passthrough watchdog.
module wb_motor_pad_mux #(
   parameter int          NUM_CH       = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h0400,
   parameter int          GUARD_CYCLES = 256,
   parameter int          WDOG_W       = 24,
   parameter int          CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic [31:0]       wb_adr_i,
   input  logic [31:0]       wb_dat_i,
   input  logic [3:0]        wb_sel_i,
   input  logic              wb_we_i,
   input  logic              wb_stb_i,
   input  logic              wb_cyc_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_stall_o,
   inout  wire  [NUM_CH-1:0] pad_motor,
   input  logic [NUM_CH-1:0] dshot_in,
   input  logic              serial_tx_i,
   input  logic              serial_oe_i,
   output logic              serial_rx_o,
   output logic              mode_o,
   output logic [CH_W-1:0]   ch_o,
   output logic              guard_o
);

   localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [CH_W-1:0] MAX_CH = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {ST_SERIAL, ST_DSHOT, ST_GUARD} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_ack;
   logic [31:0]         r_dat_o, w_rd;
   logic                r_ctrl_mode, r_pend_mode, r_mode;
   logic [CH_W-1:0]     r_ctrl_ch, r_pend_ch, r_ch;
   logic [WDOG_W-1:0]   r_wdog_lim, r_wdog_cnt;
   logic                r_wdog_fired;
   logic [GW-1:0]       r_guard_cnt;
   logic                r_rx1, r_rx2, r_rx3;

   logic                w_hit, w_wr, w_ctrl_wr, w_wr_mode, w_req_diff;
   logic [1:0]          w_reg;
   logic [CH_W-1:0]     w_raw_ch, w_wr_ch;
   logic                w_act, w_wdog_en, w_wdog_exp;
   logic                w_load_guard, w_apply, w_fire;
   logic [NUM_CH-1:0]   w_oe, w_out;
   logic                w_unused;

   assign w_hit      = wb_cyc_i & wb_stb_i & ~r_ack & (wb_adr_i[11:4] == BASE_ADDR[11:4]);
   assign w_wr       = w_hit & wb_we_i;
   assign w_reg      = wb_adr_i[3:2];
   assign w_ctrl_wr  = w_wr & (w_reg == 2'd0);
   assign w_wr_mode  = wb_dat_i[0];
   assign w_raw_ch   = wb_dat_i[CH_W:1];
   assign w_wr_ch    = (w_raw_ch > MAX_CH) ? MAX_CH : w_raw_ch;
   assign w_req_diff = {w_wr_mode, w_wr_ch} != {r_mode, r_ch};

   // Activity is the bridge driving, or an edge on the synchronised RX bit.
   assign w_act      = serial_oe_i | (r_rx2 ^ r_rx3);
   assign w_wdog_en  = (r_state == ST_SERIAL) && (r_wdog_lim != '0);
   assign w_wdog_exp = w_wdog_en && !w_act && (r_wdog_cnt >= r_wdog_lim - WDOG_W'(1));

   always_comb begin
      w_state_nxt  = r_state;
      w_load_guard = 1'b0;
      w_apply      = 1'b0;
      w_fire       = 1'b0;
      case (r_state)
         ST_GUARD: begin
            if (w_ctrl_wr) begin
               w_load_guard = 1'b1;
            end else if (r_guard_cnt == '0) begin
               w_apply     = 1'b1;
               w_state_nxt = r_pend_mode ? ST_DSHOT : ST_SERIAL;
            end
         end
         default: begin
            // A CTRL write wins over a simultaneous watchdog expiry.
            if (w_ctrl_wr) begin
               if (w_req_diff) begin
                  w_load_guard = 1'b1;
                  w_state_nxt  = ST_GUARD;
               end
            end else if (w_wdog_exp) begin
               w_fire       = 1'b1;
               w_load_guard = 1'b1;
               w_state_nxt  = ST_GUARD;
            end
         end
      endcase
   end

   always_comb begin
      w_oe  = '1;
      w_out = '0;
      if (r_state == ST_DSHOT) begin
         w_out = dshot_in;
      end else if (r_state == ST_SERIAL) begin
         w_out[r_ch] = serial_tx_i;
         w_oe[r_ch]  = serial_oe_i;
      end
   end

   always_comb begin
      w_rd = '0;
      case (w_reg)
         2'd0: begin
            w_rd[0]      = r_ctrl_mode;
            w_rd[CH_W:1] = r_ctrl_ch;
         end
         2'd1: begin
            w_rd[0]      = r_mode;
            w_rd[CH_W:1] = r_ch;
            w_rd[8]      = (r_state == ST_GUARD);
            w_rd[9]      = r_wdog_fired;
         end
         2'd2:    w_rd[WDOG_W-1:0] = r_wdog_lim;
         default: w_rd = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) r_state <= ST_SERIAL;
      else            r_state <= w_state_nxt;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         r_ack        <= 1'b0;
         r_dat_o      <= '0;
         r_ctrl_mode  <= 1'b0;
         r_ctrl_ch    <= '0;
         r_pend_mode  <= 1'b0;
         r_pend_ch    <= '0;
         r_mode       <= 1'b0;
         r_ch         <= '0;
         r_wdog_lim   <= '0;
         r_wdog_cnt   <= '0;
         r_wdog_fired <= 1'b0;
         r_guard_cnt  <= '0;
         r_rx1        <= 1'b1;
         r_rx2        <= 1'b1;
         r_rx3        <= 1'b1;
      end else begin
         r_ack <= w_hit;
         if (w_hit && !wb_we_i) r_dat_o <= w_rd;
         if (w_ctrl_wr) begin
            r_ctrl_mode <= w_wr_mode;
            r_ctrl_ch   <= w_wr_ch;
            r_pend_mode <= w_wr_mode;
            r_pend_ch   <= w_wr_ch;
         end else if (w_fire) begin
            r_pend_mode <= 1'b1;
            r_pend_ch   <= r_ch;
         end
         if (w_wr && w_reg == 2'd2) r_wdog_lim <= wb_dat_i[WDOG_W-1:0];
         if (w_fire)                                          r_wdog_fired <= 1'b1;
         else if (w_wr && w_reg == 2'd1 && wb_dat_i[9])       r_wdog_fired <= 1'b0;
         if (w_load_guard)                                    r_guard_cnt <= GW'(GUARD_CYCLES - 1);
         else if (r_state == ST_GUARD && r_guard_cnt != '0)   r_guard_cnt <= r_guard_cnt - GW'(1);
         if (w_apply) begin
            r_mode <= r_pend_mode;
            r_ch   <= r_pend_ch;
         end
         if (!w_wdog_en || w_act || w_load_guard) r_wdog_cnt <= '0;
         else                                     r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
         r_rx1 <= pad_motor[r_ch];
         r_rx2 <= r_rx1;
         r_rx3 <= r_rx2;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_pad
      assign pad_motor[i] = w_oe[i] ? w_out[i] : 1'bz;
   end

   assign wb_dat_o    = r_dat_o;
   assign wb_ack_o    = r_ack;
   assign wb_stall_o  = 1'b0;
   assign mode_o      = r_mode;
   assign ch_o        = r_ch;
   assign guard_o     = (r_state == ST_GUARD);
   assign serial_rx_o = (r_state == ST_SERIAL) ? r_rx2 : 1'b1;
   assign w_unused    = ^{wb_sel_i, wb_adr_i, wb_dat_i};

endmodule

// File: tb/tb_wb_motor_pad_mux.sv
// Directed bench for wb_motor_pad_mux: bus reads are scored by a monitor against a queue
// of expected values; pad, guard and mode behaviour is checked inline.
module tb_wb_motor_pad_mux;
   localparam int NCH = 4;
   localparam int G   = 256;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [31:0] adr = '0, wdat = '0;
   logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] dat_o, dat_o3;
   logic        ack, ack3, stall, stall3;
   wire  [NCH-1:0] pad;
   wire  [2:0]     pad3;
   logic [NCH-1:0] dshot = '0, tb_oe = 4'b0001, tb_val = 4'b0001;
   logic        tx = 1'b0, soe = 1'b0;
   logic        rx, rx3, mode, mode3, grd, grd3;
   logic [1:0]  ch, ch3;

   int n_chk = 0, n_fail = 0;
   logic [31:0] exp_q[$];
   string       name_q[$];
   logic        mon_we;
   logic [31:0] mon_exp, mon_got;
   string       mon_nm;

   always #5 clk = ~clk;

   for (genvar i = 0; i < NCH; i++) begin : g_tbpad
      assign pad[i] = tb_oe[i] ? tb_val[i] : 1'bz;
   end

   wb_motor_pad_mux #(.NUM_CH(4), .BASE_ADDR(32'h0400), .GUARD_CYCLES(G), .WDOG_W(24)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
      .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_dat_o(dat_o), .wb_ack_o(ack),
      .wb_stall_o(stall), .pad_motor(pad), .dshot_in(dshot), .serial_tx_i(tx),
      .serial_oe_i(soe), .serial_rx_o(rx), .mode_o(mode), .ch_o(ch), .guard_o(grd));

   wb_motor_pad_mux #(.NUM_CH(3), .BASE_ADDR(32'h0500), .GUARD_CYCLES(8), .WDOG_W(24)) dut3 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
      .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_dat_o(dat_o3), .wb_ack_o(ack3),
      .wb_stall_o(stall3), .pad_motor(pad3), .dshot_in(dshot[2:0]), .serial_tx_i(tx),
      .serial_oe_i(soe), .serial_rx_o(rx3), .mode_o(mode3), .ch_o(ch3), .guard_o(grd3));

   // Read-data monitor: scores every read acknowledge against the expectation queue.
   always @(posedge clk) begin
      mon_we = we;
      #1;
      if ((ack || ack3) && !mon_we) begin
         mon_got = ack3 ? dat_o3 : dat_o;
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read got=%h", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            mon_nm  = name_q.pop_front();
            if (mon_got !== mon_exp) begin
               n_fail++;
               $display("FAIL %s got=%h want=%h", mon_nm, mon_got, mon_exp);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_chk++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", nm, act, want);
      end
   endtask

   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
      int n = 0;
      @(negedge clk);
      adr = a; wdat = d; we = w; cyc = 1'b1; stb = 1'b1;
      do begin
         @(posedge clk); #1; n++;
      end while (!(ack || ack3) && n < 20);
      if (!(ack || ack3)) begin
         n_chk++; n_fail++;
         $display("FAIL wb_timeout got=no_ack want=ack adr=%h", a);
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      xfer(a, 1'b1, d);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] want, input string nm);
      exp_q.push_back(want);
      name_q.push_back(nm);
      xfer(a, 1'b0, '0);
   endtask

   // Called just after the edge that entered GUARD; counts cycles with guard_o high.
   task automatic guard_len(output int n, output int bad);
      n = 0; bad = 0;
      while (grd && n < 3000) begin
         n++;
         if (pad !== 4'b0000) bad++;
         @(posedge clk); #1;
      end
   endtask

   int n_g, bad_g, n_w;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      #1;
      chk("rst_ack", {31'd0, ack}, 0);
      chk("rst_dat", dat_o, 0);
      chk("rst_guard", {31'd0, grd}, 0);
      chk("rst_mode", {31'd0, mode}, 0);
      chk("rst_ch", {30'd0, ch}, 0);
      chk("rst_rx", {31'd0, rx}, 1);

      rd(32'h400, 32'h0, "rd_ctrl_rst");
      rd(32'h404, 32'h0, "rd_status_rst");
      rd(32'h408, 32'h0, "rd_wdog_rst");
      chk("serial_idle_pads", {29'd0, pad[3:1]}, 0);

      // Pad 0 follows TX while the bridge drives, and is released otherwise.
      @(negedge clk);
      tb_oe = '0; soe = 1'b1; tx = 1'b1; #1;
      chk("pad0_tx1", {31'd0, pad[0]}, 1);
      tx = 1'b0; #1;
      chk("pad0_tx0", {31'd0, pad[0]}, 0);
      soe = 1'b0; tx = 1'b1; tb_oe[0] = 1'b1; tb_val[0] = 1'b0; #1;
      chk("pad0_released", {31'd0, pad[0]}, 0);
      repeat (2) @(posedge clk); #1;
      chk("rx_ch0", {31'd0, rx}, 0);

      // Serial -> DSHOT through a full guard interval.
      tb_oe = '0; dshot = 4'b1010;
      wr(32'h400, 32'h1);
      guard_len(n_g, bad_g);
      chk("guard_len_dshot", n_g, G);
      chk("guard_pads_low", bad_g, 0);
      chk("dshot_pads_a", {28'd0, pad}, 32'ha);
      chk("dshot_mode", {31'd0, mode}, 1);
      dshot = 4'b0101; #1;
      chk("dshot_pads_b", {28'd0, pad}, 32'h5);
      rd(32'h404, 32'h1, "status_dshot");

      // Re-request mid-guard restarts the interval.
      wr(32'h400, 32'h6);
      repeat (100) @(posedge clk); #1;
      rd(32'h404, 32'h101, "status_in_guard");
      wr(32'h400, 32'h2);
      guard_len(n_g, bad_g);
      chk("guard_len_reload", n_g, G);
      chk("reload_pads_low", bad_g, 0);
      chk("serial_mode", {31'd0, mode}, 0);
      chk("serial_ch1", {30'd0, ch}, 1);
      tb_oe = 4'b0010; tb_val = 4'b0010;
      repeat (3) @(posedge clk); #1;
      tb_val[1] = 1'b0;
      @(posedge clk); #1;
      chk("rx_lat1", {31'd0, rx}, 1);
      @(posedge clk); #1;
      chk("rx_lat2", {31'd0, rx}, 0);
      rd(32'h400, 32'h2, "ctrl_rb");

      // Channel clamp on a 3-pad instance, and the reserved register.
      wr(32'h500, 32'h6);
      rd(32'h500, 32'h4, "ctrl_clamp");
      wr(32'h40C, 32'hFFFF_FFFF);
      rd(32'h40C, 32'h0, "reserved_rd");

      // Idle watchdog returns to DSHOT on the applied channel.
      wr(32'h408, 32'd1000);
      n_w = 0;
      while (!grd && n_w < 1200) begin
         @(posedge clk); #1; n_w++;
      end
      tb_oe = '0;
      n_chk++;
      if (n_w < 998 || n_w > 1002) begin
         n_fail++;
         $display("FAIL wdog_expiry_cycle got=%0d want=1000", n_w);
      end
      guard_len(n_g, bad_g);
      chk("guard_len_wdog", n_g, G);
      chk("wdog_mode", {31'd0, mode}, 1);
      chk("wdog_ch", {30'd0, ch}, 1);
      rd(32'h404, 32'h203, "status_fired");
      rd(32'h408, 32'd1000, "wdog_rb");
      wr(32'h404, 32'h200);
      rd(32'h404, 32'h003, "status_fired_clr");

      // CTRL write on the exact cycle the watchdog expires.
      soe = 1'b1; tx = 1'b1;
      wr(32'h408, 32'd1);
      wr(32'h400, 32'h2);
      guard_len(n_g, bad_g);
      chk("pre_race_mode", {31'd0, mode}, 0);
      chk("pre_race_ch", {30'd0, ch}, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      adr = 32'h400; wdat = 32'h4; we = 1'b1; cyc = 1'b1; stb = 1'b1; soe = 1'b0;
      @(posedge clk); #1;
      soe = 1'b1;
      chk("race_ack", {31'd0, ack}, 1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      chk("race_guard", {31'd0, grd}, 1);
      guard_len(n_g, bad_g);
      chk("race_guard_len", n_g, G);
      chk("race_mode", {31'd0, mode}, 0);
      chk("race_ch", {30'd0, ch}, 2);
      rd(32'h404, 32'h4, "race_status");

      // Reset in the middle of a guard interval.
      wr(32'h400, 32'h1);
      repeat (50) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("rst_mid_guard", {31'd0, grd}, 0);
      chk("rst_mid_mode", {31'd0, mode}, 0);
      chk("rst_mid_ch", {30'd0, ch}, 0);
      chk("rst_mid_rx", {31'd0, rx}, 1);
      @(negedge clk); rst_n = 1'b1;
      rd(32'h408, 32'h0, "wdog_after_rst");

      repeat (2) @(posedge clk); #2;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_reads got=%0d want=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
